cto2_sweep: RTL and testbench

CTO2_SWEEP -- requirements
Module: cto2_sweep

---
 rtl/cto2_pkg.sv | 23 ++
 rtl/cto2_hold_cnt.sv | 46 ++++
 rtl/cto2_sweep.sv | 144 ++++++++++++++
 tb/tb_cto2_sweep.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cto2_pkg.sv
// ============================================================================
// Module : cto2_pkg
// Shared types and constants for the cto2_sweep response-signature block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cto2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned VEC_W  = 3;
  localparam int unsigned SIG_W  = 8;
  localparam int unsigned HOLD_W = 4;
  localparam logic [SIG_W-1:0] GOLDEN_SIG = 8'h1A;

endpackage

`default_nettype wire

// File: rtl/cto2_hold_cnt.sv
// ============================================================================
// Module : cto2_hold_cnt
// Counts cycles a stimulus vector is held; tc_o flags the last held cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cto2_hold_cnt
  import cto2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [HOLD_W-1:0] C_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cto2_sweep.sv
// ============================================================================
// Module : cto2_sweep
// Drives all eight {a,b,c} vectors, captures the returned bit s into an
// 8-bit signature and optionally compares it to EXPECTED.
// Optional feature macro: CTO2_SWEEP_CHECK_EN (signature comparator / match).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cto2_sweep
  import cto2_pkg::*;
#(
  parameter int unsigned      HOLD_CYCLES = 1,
  parameter logic [SIG_W-1:0] EXPECTED    = GOLDEN_SIG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             s,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] resp,
  output logic             match
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   abc_q, abc_d;
  logic [SIG_W-1:0]   resp_q, resp_d;
  logic               done_q, done_d;
  logic               start_acc;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_tc;

  cto2_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    abc_d     = abc_q;
    resp_d    = resp_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = DRIVE;
          idx_d     = '0;
          abc_d     = '0;
          resp_d    = '0;
          start_acc = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          abc_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            resp_d[idx_q] = s;
            idx_d         = idx_q + 1'b1;
            // Last vector sampled: return the bus to zero instead of a ninth vector.
            if (idx_q == VEC_W'(7)) begin
              state_d = DONE;
              abc_d   = '0;
            end else begin
              abc_d = idx_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        abc_d   = '0;
        done_d  = !abort;
      end
      default: begin
        state_d = IDLE;
        abc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      resp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
    end
  end

`ifdef CTO2_SWEEP_CHECK_EN
  logic match_q;

  // Compare happens on the DONE->IDLE edge so match rises together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if (start_acc) begin
      match_q <= 1'b0;
    end else if (done_d) begin
      match_q <= (resp_q == EXPECTED);
    end
  end

  assign match = match_q;
`else
  assign match = 1'b0;
`endif

  assign {a, b, c} = abc_q;
  assign busy      = (state_q == DRIVE);
  assign done      = done_q;
  assign resp      = resp_q;

endmodule

`default_nettype wire

// File: tb/tb_cto2_sweep.sv
// ============================================================================
// Module : tb_cto2_sweep
// Directed bench for cto2_sweep with HOLD_CYCLES of 1 and 3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cto2_sweep;

`ifdef CTO2_SWEEP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, abort1, start3, abort3;
  logic       s1, s3;
  logic       a1, b1, c1, busy1, done1, match1;
  logic       a3, b3, c3, busy3, done3, match3;
  logic [7:0] resp1, resp3;
  int         s_mode;
  logic       sel3;
  int         n_vec = 0;
  int         n_err = 0;

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_match;
  logic [7:0] o_resp;

  always #5 clk = ~clk;

  // Reference combinational stage: truth table whose signature is 8'h1A.
  function automatic logic stage(input int m, input logic [2:0] v);
    logic [7:0] g;
    g = 8'h1A;
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return g[v];
  endfunction

  assign s1 = stage(s_mode, {a1, b1, c1});
  assign s3 = stage(s_mode, {a3, b3, c3});

  always_comb begin
    o_abc   = sel3 ? {a3, b3, c3} : {a1, b1, c1};
    o_busy  = sel3 ? busy3 : busy1;
    o_done  = sel3 ? done3 : done1;
    o_match = sel3 ? match3 : match1;
    o_resp  = sel3 ? resp3 : resp1;
  end

  cto2_sweep #(.HOLD_CYCLES(1), .EXPECTED(8'h1A)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .s(s1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .resp(resp1), .match(match1)
  );

  cto2_sweep #(.HOLD_CYCLES(3), .EXPECTED(8'h1A)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .s(s3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
    .resp(resp3), .match(match3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int h, input logic v);
    if (h == 3) start3 = v;
    else        start1 = v;
  endtask

  // Full sweep; start is also pulsed mid-sweep and during DONE to show it is ignored.
  task automatic sweep(input int h, input logic [7:0] er, input logic em, input string tg);
    sel3 = (h == 3);
    set_start(h, 1'b1);
    tick();
    set_start(h, 1'b0);
    chk({tg, "_busy_e0"}, 32'(o_busy), 32'd1);
    chk({tg, "_abc_e0"}, 32'(o_abc), 32'd0);
    for (int e = 1; e <= 8 * h; e++) begin
      tick();
      chk({tg, "_abc"}, 32'(o_abc), (e < 8 * h) ? 32'(e / h) : 32'd0);
      chk({tg, "_busy"}, 32'(o_busy), (e < 8 * h) ? 32'd1 : 32'd0);
      chk({tg, "_done_early"}, 32'(o_done), 32'd0);
      set_start(h, (e == 1) || (e == 8 * h));
    end
    tick();
    set_start(h, 1'b0);
    chk({tg, "_done"}, 32'(o_done), 32'd1);
    chk({tg, "_resp"}, 32'(o_resp), 32'(er));
    chk({tg, "_match"}, 32'(o_match), 32'(em));
    chk({tg, "_busy_done"}, 32'(o_busy), 32'd0);
    tick();
    chk({tg, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tg, "_busy_idle"}, 32'(o_busy), 32'd0);
    chk({tg, "_resp_hold"}, 32'(o_resp), 32'(er));
    chk({tg, "_match_hold"}, 32'(o_match), 32'(em));
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    s_mode = 0; sel3 = 1'b0;
    tick();
    tick();
    chk("rst_abc1", 32'({a1, b1, c1}), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_resp1", 32'(resp1), 32'd0);
    chk("rst_match1", 32'(match1), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_resp3", 32'(resp3), 32'd0);
    rst = 1'b0;
    tick();

    sweep(1, 8'h1A, CHK, "gold_h1");
    sweep(3, 8'h1A, CHK, "gold_h3");
    s_mode = 1;
    sweep(1, 8'hFF, 1'b0, "ones_h1");
    s_mode = 2;
    sweep(1, 8'h00, 1'b0, "zeros_h1");
    s_mode = 0;
    sweep(1, 8'h1A, CHK, "gold2_h1");

    // Abort sampled at edge 4: vectors 0..2 captured, vector 3 discarded.
    sel3 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_abc", 32'({a1, b1, c1}), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_resp", 32'(resp1), 32'h02);
    chk("abort_match", 32'(match1), 32'd0);
    tick();
    chk("abort_no_done", 32'(done1), 32'd0);
    chk("abort_resp_hold", 32'(resp1), 32'h02);

    start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    chk("abort_wins_busy", 32'(busy1), 32'd0);
    chk("abort_wins_resp", 32'(resp1), 32'h02);
    tick();
    chk("abort_wins_idle", 32'(busy1), 32'd0);

    // Reset mid-sweep.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(busy1), 32'd1);
    chk("mid_abc", 32'({a1, b1, c1}), 32'd2);
    chk("mid_resp", 32'(resp1), 32'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_abc", 32'({a1, b1, c1}), 32'd0);
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_done", 32'(done1), 32'd0);
    chk("mrst_resp", 32'(resp1), 32'd0);
    chk("mrst_match", 32'(match1), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mrst_no_done", 32'(done1), 32'd0);
      chk("mrst_idle", 32'(busy1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
